jk_excitation_driver: RTL and testbench
=======================================

// Module: jk_excitation_driver
// PURPOSE
//   Write side of the JK register interface. Accepts a target N-bit state over valid/ready.
//   Computes per-bit J/K excitation from the live Q feedback and drives J/K for one clock.
//   After a settle delay it checks the feedback, retries on mismatch, then reports done or mismatch.
//   Sits between control logic and a bank of JK flip-flops (J,K,clk,reset -> Q).
// PARAMETERS
//   WIDTH          4   number of JK bits driven / fed back
//   SETTLE_CYCLES  1   cycles J=K=0 after drive before Q is sampled (>=1)
//   MAX_RETRY      2   re-drive attempts after first failed check (0 = no retry)
// PORTS
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous, active-low reset
//   tgt_valid  in   1      target word offered
//   tgt_ready  out  1      driver can accept target (high only in IDLE)
//   tgt_data   in   WIDTH  desired Q state
//   q_fb       in   WIDTH  Q outputs of the driven JK bank
//   j_out      out  WIDTH  J inputs to JK bank
//   k_out      out  WIDTH  K inputs to JK bank
//   busy       out  1      transaction in progress (state != IDLE)
//   done       out  1      1-cycle pulse: q_fb == target after check
//   mismatch   out  1      1-cycle pulse: retries exhausted, q_fb != target
// BEHAVIOUR
//   Reset (reset==0, async): state=IDLE, j_out=k_out=0, done=mismatch=0, busy=0, retry=0, tgt_q=0.
//   All outputs registered; tgt_ready=1 out of reset (IDLE).
//   States: IDLE -> DRIVE -> SETTLE -> CHECK -> {IDLE | DRIVE}.
//   IDLE: tgt_ready=1. On tgt_valid&tgt_ready: tgt_q<=tgt_data, retry<=0, go DRIVE.
//   DRIVE (exactly 1 cycle): j_out/k_out = excite(q_fb, tgt_q), per bit:
//     0->0: J=0 K=0 | 0->1: J=1 K=0 | 1->0: J=0 K=1 | 1->1: J=0 K=0.
//   SETTLE: j_out=k_out=0; count SETTLE_CYCLES cycles, then go CHECK.
//   CHECK (1 cycle, J=K=0):
//     q_fb==tgt_q -> done=1 next cycle, go IDLE.
//     q_fb!=tgt_q & retry<MAX_RETRY -> retry++, go DRIVE with excitation recomputed from current q_fb.
//     Otherwise -> mismatch=1 next cycle, go IDLE.
//   Latency on a healthy bank: accept -> done = 3+SETTLE_CYCLES cycles.
//   tgt_data == q_fb at accept: DRIVE still occurs with all-zero J/K; done is still pulsed.
//   tgt_valid while busy: ignored (ready low); no queuing.
//   done and mismatch are never both high. Each is a single pulse per transaction.
//   Reset mid-transaction: immediate abort, J/K forced 0, no done/mismatch pulse.
//   Retry counter is width clog2(MAX_RETRY+1) and saturates; no wrap.
// CONFIGURATION
//   JKX_TOGGLE_EN defined: changing bits are driven with J=K=1 (toggle); unchanged bits get J=K=0.
//     CHECK/retry rules are unchanged. A retry re-toggles only bits that still differ.
//   Undefined: set/reset encoding per the DRIVE table above; J=K=1 is never emitted.
// STRUCTURE
//   Package jk_exc_pkg:
//     state enum {IDLE,DRIVE,SETTLE,CHECK};
//     localparams JK_HOLD=2'b00, JK_RESET=2'b01, JK_SET=2'b10, JK_TOGGLE=2'b11;
//     function excite(q,t).
//   Sub-module jk_excite_cell: 1-bit combinational q,t -> {j,k}, honours JKX_TOGGLE_EN.
//     Instanced WIDTH times via generate.
//   Top: FSM, settle counter, retry counter, output registers.
// TESTING
//   Bench instantiates WIDTH JK flip-flops fed by j_out/k_out, with q_fb=Q. Clock period 100 ns.
//   1 Reset: hold reset=0 for 2 cycles with tgt_valid=1 -> j_out=k_out=0, busy=0, no done;
//     tgt_ready=1 after release.
//   2 Set pattern: Q=4'b0000, send 4'b1010 -> DRIVE shows j=1010 k=0000;
//     done at cycle 4 after accept; Q=1010.
//   3 Mixed: Q=4'b1010, send 4'b0110 -> j=0100 k=1000 (toggle build: j=k=1100); done, Q=0110.
//   4 Stuck bit: force q_fb[0]=0, send 4'b0001 -> 3 DRIVE phases (MAX_RETRY=2),
//     one mismatch pulse, no done.
//   5 Back-pressure: tgt_valid held with new data while busy -> not accepted until IDLE;
//     second word accepted the cycle tgt_ready rises.
//   6 Reset mid-SETTLE: reset=0 -> outputs 0 same cycle, no pulse;
//     next transaction completes normally.

Source files
------------

// File: rtl/jk_excitation_driver_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | jk_exc_pkg : shared states, JK codes and the per-bit excitation function.  |
// | Optional feature macro: JKX_TOGGLE_EN (toggle-based excitation).           |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package jk_exc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } state_t;

  // {J,K} codes
  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  function automatic logic [1:0] excite(input logic q, input logic t);
`ifdef JKX_TOGGLE_EN
    excite = (q != t) ? JK_TOGGLE : JK_HOLD;
`else
    case ({q, t})
      2'b01:   excite = JK_SET;
      2'b10:   excite = JK_RESET;
      default: excite = JK_HOLD;
    endcase
`endif
  endfunction

endpackage
`default_nettype wire

// File: rtl/jk_excitation_driver_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | jk_excitation_driver_if : target handshake, JK drive and status bundle.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface jk_excitation_driver_if #(
  parameter int WIDTH = 4
);
  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] tgt_data;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] j_out;
  logic [WIDTH-1:0] k_out;
  logic             busy;
  logic             done;
  logic             mismatch;

  modport master (
    output tgt_valid, tgt_data, q_fb,
    input  tgt_ready, j_out, k_out, busy, done, mismatch
  );

  modport slave (
    input  tgt_valid, tgt_data, q_fb,
    output tgt_ready, j_out, k_out, busy, done, mismatch
  );
endinterface
`default_nettype wire

// File: rtl/jk_excitation_driver_cell.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | jk_excite_cell : 1-bit combinational {J,K} from current Q and target bit.  |
// | Honours JKX_TOGGLE_EN through the package excite() function.               |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module jk_excite_cell
  import jk_exc_pkg::*;
(
  input  wire logic i_q,
  input  wire logic i_t,
  output logic      o_j,
  output logic      o_k
);
  logic [1:0] w_jk;

  assign w_jk = excite(i_q, i_t);
  assign o_j  = w_jk[1];
  assign o_k  = w_jk[0];
endmodule
`default_nettype wire

// File: rtl/jk_excitation_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | jk_excitation_driver : drives a JK bank to a target word, verifies Q and   |
// | retries. Optional macro JKX_TOGGLE_EN selects toggle excitation.           |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module jk_excitation_driver
  import jk_exc_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int MAX_RETRY     = 2
) (
  input  wire logic               clk,
  input  wire logic               reset,
  jk_excitation_driver_if.slave   bus
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [SW-1:0] c_SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [RW-1:0] c_MAX_RETRY   = RW'(MAX_RETRY);

  state_t           r_state;
  logic [WIDTH-1:0] r_tgt_q;
  logic [WIDTH-1:0] r_j;
  logic [WIDTH-1:0] r_k;
  logic [SW-1:0]    r_settle;
  logic [RW-1:0]    r_retry;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic             r_mismatch;

  logic [WIDTH-1:0] w_tsel;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic             w_accept;
  logic             w_match;

  // In IDLE the excitation targets the offered word; afterwards the latched one.
  assign w_tsel   = (r_state == IDLE) ? bus.tgt_data : r_tgt_q;
  assign w_accept = bus.tgt_valid & r_ready;
  assign w_match  = (bus.q_fb == r_tgt_q);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      jk_excite_cell u_cell (
        .i_q (bus.q_fb[gi]),
        .i_t (w_tsel[gi]),
        .o_j (w_j[gi]),
        .o_k (w_k[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_tgt_q    <= '0;
      r_j        <= '0;
      r_k        <= '0;
      r_settle   <= '0;
      r_retry    <= '0;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_mismatch <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_mismatch <= 1'b0;
      r_j        <= '0;
      r_k        <= '0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_tgt_q <= bus.tgt_data;
            r_retry <= '0;
            r_j     <= w_j;
            r_k     <= w_k;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= DRIVE;
          end
        end
        DRIVE: begin
          r_settle <= '0;
          r_state  <= SETTLE;
        end
        SETTLE: begin
          if (r_settle == c_SETTLE_LAST) begin
            r_state <= CHECK;
          end else begin
            r_settle <= r_settle + SW'(1);
          end
        end
        CHECK: begin
          if (w_match) begin
            r_done  <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (r_retry < c_MAX_RETRY) begin
            // Re-drive from the live feedback so only wrong bits are excited.
            r_retry <= r_retry + RW'(1);
            r_j     <= w_j;
            r_k     <= w_k;
            r_state <= DRIVE;
          end else begin
            r_mismatch <= 1'b1;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.tgt_ready = r_ready;
  assign bus.j_out     = r_j;
  assign bus.k_out     = r_k;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.mismatch  = r_mismatch;

endmodule
`default_nettype wire

// File: tb/tb_jk_excitation_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_jk_excitation_driver : JK bank model plus scoreboard around the driver. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_jk_excitation_driver;

  localparam int WIDTH = 4;

`ifdef JKX_TOGGLE_EN
  localparam logic [3:0] c_T2_J = 4'b1010, c_T2_K = 4'b1010;
  localparam logic [3:0] c_T3_J = 4'b1100, c_T3_K = 4'b1100;
  localparam logic [3:0] c_T6_J = 4'b1001, c_T6_K = 4'b1001;
`else
  localparam logic [3:0] c_T2_J = 4'b1010, c_T2_K = 4'b0000;
  localparam logic [3:0] c_T3_J = 4'b0100, c_T3_K = 4'b1000;
  localparam logic [3:0] c_T6_J = 4'b1001, c_T6_K = 4'b0000;
`endif

  typedef struct {
    logic [3:0] tgt;
    logic [3:0] ej;
    logic [3:0] ek;
    bit         chk_jk;
    bit         exp_done;
    int         drives;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #50 clk = ~clk;

  jk_excitation_driver_if #(.WIDTH(WIDTH)) bus ();

  jk_excitation_driver #(
    .WIDTH         (WIDTH),
    .SETTLE_CYCLES (1),
    .MAX_RETRY     (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // JK flip-flop bank with an optional stuck-at-0 fault on bit 0 feedback
  logic [3:0] r_q;
  logic       stuck0 = 1'b0;
  assign bus.q_fb = r_q & ~{3'b000, stuck0};

  always @(posedge clk or negedge reset) begin
    if (!reset) r_q <= '0;
    else begin
      for (int i = 0; i < WIDTH; i++) begin
        case ({bus.j_out[i], bus.k_out[i]})
          2'b01:   r_q[i] <= 1'b0;
          2'b10:   r_q[i] <= 1'b1;
          2'b11:   r_q[i] <= ~r_q[i];
          default: r_q[i] <= r_q[i];
        endcase
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  exp_t sb[$];

  // Monitor: tracks the live transaction and pops the scoreboard on each pulse
  bit         mon_active = 0;
  int         mon_cyc = 0;
  int         mon_drv = 0;
  logic [3:0] mon_j = '0;
  logic [3:0] mon_k = '0;

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      mon_active = 0;
    end else begin
      if (mon_active) begin
        mon_cyc++;
        if (mon_cyc == 1) begin
          mon_j = bus.j_out;
          mon_k = bus.k_out;
        end
        if ((bus.j_out | bus.k_out) != 4'b0000) mon_drv++;
      end
      if (bus.done || bus.mismatch) begin
        check_val("pulse_exclusive", 32'(bus.done & bus.mismatch), 0);
        if (sb.size() == 0) begin
          check_val("spurious_pulse", 1, 0);
        end else begin
          e = sb.pop_front();
          check_val("done", 32'(bus.done), 32'(e.exp_done));
          check_val("mismatch", 32'(bus.mismatch), 32'(!e.exp_done));
          check_val("latency", mon_cyc, e.lat);
          check_val("drive_phases", mon_drv, e.drives);
          if (e.chk_jk) begin
            check_val("first_j", 32'(mon_j), 32'(e.ej));
            check_val("first_k", 32'(mon_k), 32'(e.ek));
          end
          if (e.exp_done) check_val("final_q", 32'(bus.q_fb), 32'(e.tgt));
        end
        mon_active = 0;
      end
      if (bus.tgt_valid && bus.tgt_ready) begin
        mon_active = 1;
        mon_cyc    = 0;
        mon_drv    = 0;
      end
    end
  end

  task automatic push_exp(input logic [3:0] d, input logic [3:0] ej, input logic [3:0] ek,
                          input bit cj, input bit ed, input int drv, input int lat);
    exp_t e;
    e.tgt = d; e.ej = ej; e.ek = ek; e.chk_jk = cj;
    e.exp_done = ed; e.drives = drv; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic send(input logic [3:0] d, input logic [3:0] ej, input logic [3:0] ek,
                      input bit cj, input bit ed, input int drv, input int lat);
    int n = 0;
    push_exp(d, ej, ek, cj, ed, drv, lat);
    @(posedge clk); #1;
    bus.tgt_data  = d;
    bus.tgt_valid = 1'b1;
    while (!bus.tgt_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    bus.tgt_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_val("drain_timeout", sb.size(), 0);
    sb.delete();
    @(negedge clk);
    check_val("idle_ready", 32'(bus.tgt_ready), 1);
    check_val("idle_busy", 32'(bus.busy), 0);
  endtask

  initial begin
    int lowcnt;
    int n;
    int pulses;
    bus.tgt_valid = 1'b1;
    bus.tgt_data  = 4'b1111;

    // Reset held with a pending offer
    repeat (2) @(negedge clk);
    check_val("rst_j", 32'(bus.j_out), 0);
    check_val("rst_k", 32'(bus.k_out), 0);
    check_val("rst_busy", 32'(bus.busy), 0);
    check_val("rst_done", 32'(bus.done | bus.mismatch), 0);
    @(posedge clk); #1;
    bus.tgt_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_val("rst_ready", 32'(bus.tgt_ready), 1);

    // Set pattern, then target equal to Q, then mixed set/reset
    send(4'b1010, c_T2_J, c_T2_K, 1, 1, 1, 4);
    wait_idle();
    send(4'b1010, 4'b0000, 4'b0000, 1, 1, 0, 4);
    wait_idle();
    send(4'b0110, c_T3_J, c_T3_K, 1, 1, 1, 4);
    wait_idle();

    // Stuck feedback bit: initial drive plus two retries, then mismatch
    stuck0 = 1'b1;
    send(4'b0001, 4'b0000, 4'b0000, 0, 0, 3, 10);
    wait_idle();
    stuck0 = 1'b0;

    // Back-pressure: second word held while busy
    push_exp(4'b0011, 4'b0000, 4'b0000, 0, 1, 1, 4);
    push_exp(4'b1100, 4'b0000, 4'b0000, 0, 1, 1, 4);
    @(posedge clk); #1;
    bus.tgt_data  = 4'b0011;
    bus.tgt_valid = 1'b1;
    @(posedge clk); #1;
    bus.tgt_data = 4'b1100;
    lowcnt = 0;
    n = 0;
    do begin
      @(negedge clk);
      if (!bus.tgt_ready) lowcnt++;
      n++;
    end while (!bus.tgt_ready && n < 20);
    check_val("bp_ready_low_cycles", lowcnt, 3);
    check_val("bp_done_with_ready", 32'(bus.done), 1);
    @(posedge clk); #1;
    bus.tgt_valid = 1'b0;
    wait_idle();

    // Asynchronous reset while settling aborts without a pulse
    send(4'b0101, 4'b0000, 4'b0000, 0, 1, 1, 4);
    @(posedge clk); #20;
    check_val("abort_busy_before", 32'(bus.busy), 1);
    reset = 1'b0;
    #1;
    sb.delete();
    check_val("abort_j", 32'(bus.j_out), 0);
    check_val("abort_k", 32'(bus.k_out), 0);
    check_val("abort_busy", 32'(bus.busy), 0);
    check_val("abort_ready", 32'(bus.tgt_ready), 1);
    @(posedge clk); #1;
    reset = 1'b1;
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      pulses += int'(bus.done | bus.mismatch);
    end
    check_val("abort_no_pulse", pulses, 0);

    send(4'b1001, c_T6_J, c_T6_K, 1, 1, 1, 4);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
